// File: rtl/fifo_uart_tx.sv
// Drain stage for the byte FIFO: pops one word at a time over the registered read port
// and serialises it as a UART frame. An empty FIFO is re-polled only after a back-off gap.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int POLL_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_val,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    // state   | meaning
    // IDLE    | line idle, waiting for enable
    // REQ     | read strobe to FIFO this cycle
    // WAIT    | FIFO read data/valid present, decide frame or back-off
    // START   | start bit (tx low)
    // DATA    | data bits, LSB first
    // STOP    | stop bit(s), byte_done on the final cycle
    // BACKOFF | FIFO was empty, hold off before the next poll
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        START,
        DATA,
        STOP,
        BACKOFF
    } state_t;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int GAP_W  = $clog2(POLL_GAP + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);

    state_t                state, state_nxt;
    logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
    logic [BIT_W-1:0]      bit_idx, bit_nxt;
    logic [GAP_W-1:0]      gap_cnt, gap_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic                  baud_last;
    logic                  tx_nxt;
    logic                  busy_nxt;
    logic                  rd_en_nxt;
    logic                  done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            shift_reg  <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_idx    <= bit_nxt;
            gap_cnt    <= gap_nxt;
            shift_reg  <= shift_nxt;
            tx         <= tx_nxt;
            busy       <= busy_nxt;
            fifo_rd_en <= rd_en_nxt;
            byte_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        gap_nxt   = gap_cnt;
        shift_nxt = shift_reg;
        baud_last = (baud_cnt == BAUD_LAST);

        case (state)
            IDLE: begin
                if (enable) state_nxt = REQ;
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (fifo_rd_val) begin
                    shift_nxt = fifo_rd_data;
                    baud_nxt  = '0;
                    state_nxt = START;
                end else begin
                    gap_nxt   = '0;
                    state_nxt = BACKOFF;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = enable ? REQ : IDLE;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            BACKOFF: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next-state values so the registers line up with the state.
        tx_nxt = 1'b1;
        if (state_nxt == START) begin
            tx_nxt = 1'b0;
        end else if (state_nxt == DATA) begin
            tx_nxt = shift_nxt[0];
        end
        busy_nxt  = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP);
        rd_en_nxt = (state_nxt == REQ);
        done_nxt  = (state_nxt == STOP) && (baud_nxt == BAUD_LAST) && (bit_nxt == STOP_LAST);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, frame-level line monitor and randomized traffic.
module tb_fifo_uart_tx;
    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int SB    = 1;
    localparam int PG    = 4;
    localparam int FRAME = (1 + DW + SB) * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_val = 1'b0;
    logic       tx;
    logic       busy;
    logic       byte_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB),
        .POLL_GAP    (PG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_val (fifo_rd_val),
        .tx          (tx),
        .busy        (busy),
        .byte_done   (byte_done)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // FIFO model: registered read, rd_val is noise whenever no read was issued
    logic [7:0] fifo_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] pop_d;
    logic [7:0] last_popped = 8'h00;
    int         pops = 0;

    always @(posedge clk) begin
        if (fifo_rd_en && !reset) begin
            if (fifo_q.size() > 0) begin
                pop_d = fifo_q.pop_front();
                fifo_rd_data <= pop_d;
                fifo_rd_val  <= 1'b1;
                sent_q.push_back(pop_d);
                last_popped = pop_d;
                pops++;
            end else begin
                fifo_rd_data <= 8'($urandom);
                fifo_rd_val  <= 1'b0;
            end
        end else begin
            fifo_rd_data <= 8'($urandom);
            fifo_rd_val  <= 1'($urandom);
        end
    end

    // Line monitor: expected waveform of each frame is built from the byte the FIFO handed out
    bit         in_frame = 1'b0;
    int         fcyc = 0;
    logic [7:0] exp_byte = 8'h00;
    logic       exp_bit;
    int         tx_bad = 0, busy_bad = 0, done_bad = 0;
    int         frames_done = 0, last_gap = 0, idle_run = 0;
    int         rd_cnt = 0, rd_dbl = 0, rd_busy = 0, idle_bad = 0, spurious = 0;
    bit         prev_rd = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
            prev_rd  = 1'b0;
            idle_run = 0;
            sent_q.delete();
        end else begin
            if (fifo_rd_en) begin
                rd_cnt++;
                if (prev_rd) rd_dbl++;
                if (busy) rd_busy++;
            end
            prev_rd = fifo_rd_en;
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1'b1;
                fcyc     = 0;
                last_gap = idle_run;
                tx_bad   = 0;
                busy_bad = 0;
                done_bad = 0;
                if (sent_q.size() == 0) begin
                    spurious++;
                    exp_byte = 8'h00;
                end else begin
                    exp_byte = sent_q.pop_front();
                end
            end
            if (in_frame) begin
                if (fcyc / CPB == 0)       exp_bit = 1'b0;
                else if (fcyc / CPB <= DW) exp_bit = exp_byte[fcyc / CPB - 1];
                else                       exp_bit = 1'b1;
                if (tx !== exp_bit) tx_bad++;
                if (busy !== 1'b1) busy_bad++;
                if (byte_done !== (fcyc == FRAME - 1)) done_bad++;
                if (fcyc == FRAME - 1) begin
                    chk("frame_tx", tx_bad, 0);
                    chk("frame_busy", busy_bad, 0);
                    chk("frame_byte_done", done_bad, 0);
                    in_frame = 1'b0;
                    idle_run = 0;
                    frames_done++;
                end else begin
                    fcyc++;
                end
            end else begin
                idle_run++;
                if (busy || byte_done) idle_bad++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int t = 0;
        while (frames_done < target && t < budget) begin
            tick(1);
            t++;
        end
        if (frames_done < target) chk("wait_frames_timeout", frames_done, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0, p0, t, t_prev, polls, line_bad;

        tick(3);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_en", int'(fifo_rd_en), 0);
        chk("reset_byte_done", int'(byte_done), 0);
        reset = 1'b0;
        tick(5);
        chk("idle_no_rd_en", rd_cnt, 0);

        // single byte 0xA5
        f0 = frames_done; r0 = rd_cnt;
        fifo_q.push_back(8'hA5);
        enable = 1'b1;
        wait_frames(f0 + 1, 200);
        enable = 1'b0;
        tick(20);
        chk("a5_rd_en_pulses", rd_cnt - r0, 1);
        chk("a5_popped", int'(last_popped), 8'hA5);

        // back-to-back 0x01, 0xFF
        f0 = frames_done; r0 = rd_cnt;
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'hFF);
        enable = 1'b1;
        wait_frames(f0 + 2, 300);
        enable = 1'b0;
        tick(20);
        chk("b2b_gap", last_gap, 2);
        chk("b2b_rd_en_pulses", rd_cnt - r0, 2);

        // empty FIFO polling cadence
        t_prev = -1; polls = 0; line_bad = 0;
        enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) line_bad++;
            if (fifo_rd_en) begin
                if (t_prev >= 0) chk("poll_interval", c - t_prev, 7);
                t_prev = c;
                polls++;
            end
        end
        enable = 1'b0;
        tick(20);
        chk("poll_line_idle", line_bad, 0);
        chk("poll_count_ok", int'(polls >= 8), 1);

        // byte arrives while backing off after an empty poll
        f0 = frames_done; r0 = rd_cnt;
        enable = 1'b1;
        t = 0;
        while (!fifo_rd_en && t < 30) begin tick(1); t++; end
        chk("bo_first_poll_seen", int'(fifo_rd_en), 1);
        tick(3);
        fifo_q.push_back(8'h5A);
        wait_frames(f0 + 1, 200);
        enable = 1'b0;
        tick(20);
        chk("bo_popped", int'(last_popped), 8'h5A);
        chk("bo_rd_en_pulses", rd_cnt - r0, 2);

        // enable dropped during the third data bit
        f0 = frames_done; r0 = rd_cnt;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h77);
        enable = 1'b1;
        t = 0;
        while (!(in_frame && fcyc == 13) && t < 100) begin tick(1); t++; end
        chk("drop_reached_bit2", fcyc, 13);
        enable = 1'b0;
        wait_frames(f0 + 1, 200);
        tick(60);
        chk("drop_frames", frames_done - f0, 1);
        chk("drop_rd_en_pulses", rd_cnt - r0, 1);
        chk("drop_fifo_left", fifo_q.size(), 1);
        fifo_q.delete();

        // asynchronous reset mid-frame
        fifo_q.push_back(8'hC3);
        enable = 1'b1;
        t = 0;
        while (!(in_frame && fcyc == 20) && t < 100) begin tick(1); t++; end
        #2;
        reset = 1'b1;
        #1;
        chk("areset_tx", int'(tx), 1);
        chk("areset_busy", int'(busy), 0);
        chk("areset_rd_en", int'(fifo_rd_en), 0);
        tick(2);
        fifo_q.push_back(8'h96);
        f0 = frames_done; r0 = rd_cnt;
        reset = 1'b0;
        wait_frames(f0 + 1, 200);
        enable = 1'b0;
        tick(20);
        chk("areset_popped", int'(last_popped), 8'h96);
        chk("areset_rd_en_pulses", rd_cnt - r0, 1);

        // randomized traffic with enable toggling
        f0 = frames_done; p0 = pops;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            if ($urandom_range(0, 19) == 0 && fifo_q.size() < 6) fifo_q.push_back(8'($urandom));
            if ($urandom_range(0, 99) == 0) enable = ~enable;
        end
        enable = 1'b1;
        t = 0;
        while (!(fifo_q.size() == 0 && sent_q.size() == 0 && !in_frame) && t < 3000) begin
            tick(1);
            t++;
        end
        chk("rand_drained", int'(fifo_q.size() == 0 && sent_q.size() == 0 && !in_frame), 1);
        enable = 1'b0;
        tick(50);
        chk("rand_frames_vs_pops", frames_done - f0, pops - p0);

        chk("rd_en_double_pulse", rd_dbl, 0);
        chk("rd_en_while_busy", rd_busy, 0);
        chk("idle_busy_or_done", idle_bad, 0);
        chk("spurious_frames", spurious, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
